door_actuator_model: RTL
========================

DOOR_ACTUATOR_MODEL -- requirements
Module: door_actuator_model

Interface
REQ-001 Parameter TRAVEL, default 8, is the number of position steps from a closed leaf to a fully open leaf (legal range 2..255).
REQ-002 Parameter STEP_DIV, default 2, is the number of consecutive command cycles per position step (legal range 1..16).
REQ-003 Parameter STALL_CYC, default 6, is the number of jammed command cycles before a stall is flagged.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 m2l, l2m  input  1 each  left motor commands: open left leaf, close left leaf.
REQ-007 m2r, r2m  input  1 each  right motor commands: open right leaf, close right leaf.
REQ-008 bt  input  1  bolt engaged; blocks opening motion.
REQ-009 jam  input  1  obstruction injection; present only with DOOR_JAM_EN.
REQ-010 l, r  output  1 each  left/right open-limit switch (leaf position == TRAVEL).
REQ-011 m  output  1  middle limit switch (both leaf positions == 0).
REQ-012 lpos, rpos  output  8 each  current leaf positions.
REQ-013 fault  output  1  sticky: conflicting commands detected.
REQ-014 stall  output  1  sticky: motor held against a jam.

Function
REQ-015 Each leaf SHALL run an FSM with states CLOSED, OPENING, OPEN, CLOSING, HALTED (stopped between limits) and FAULT.
- Open command -> OPENING.
- Close command -> CLOSING.
- No command between limits -> HALTED.
REQ-016 A per-leaf divider SHALL count consecutive cycles of one unchanged command; the position moves one step when the count reaches STEP_DIV, after which the divider clears.
REQ-017 The divider SHALL clear when the command drops or changes direction, so a reversal restarts a full STEP_DIV period.
REQ-018 Position SHALL saturate at 0 and TRAVEL and never wrap. A command held at its limit holds the state (CLOSED or OPEN) with no movement.
REQ-019 l, r and m SHALL be combinational decodes of the position registers, so there is zero extra latency after the stepping edge.
REQ-020 With bt=1, opening commands SHALL be ignored (no divider count, no movement); closing commands still act.
REQ-021 Open and close asserted together for one leaf in the same cycle SHALL move that leaf to FAULT on the next edge.
- FAULT freezes the leaf position and sets fault=1.
- FAULT is left only by reset.
- The other leaf is unaffected.
REQ-022 The two leaves SHALL operate independently and concurrently. m=1 only when both positions are 0.

Reset
REQ-023 While reset=0 at a rising edge, the block SHALL load these values, including when reset arrives mid-travel or in FAULT:
- lpos=rpos=0
- both FSMs CLOSED
- dividers and stall counters 0
- fault=0, stall=0
Resulting outputs: m=1, l=0, r=0.

Configuration
REQ-024 With DOOR_JAM_EN defined, port jam SHALL exist and behave as follows:
- jam=1 freezes both positions and dividers.
- Each cycle jam=1 with any effective motor command increments a stall counter; the counter clears when jam=0.
- At STALL_CYC, stall is set to 1 and stays set until reset.
REQ-025 Without DOOR_JAM_EN, port jam SHALL be absent, stall SHALL be tied 0, and the stall counter logic SHALL not be synthesized.

Structure
REQ-026 A shared package SHALL hold the leaf state enum, the 8-bit position type, and the default TRAVEL, STEP_DIV and STALL_CYC constants.
REQ-027 The single-leaf FSM, divider and saturating position SHALL be sub-module door_leaf, instantiated twice (left, right). The top level holds the limit decode, fault/stall ORing and jam gating.

Verification (TRAVEL=4, STEP_DIV=2, STALL_CYC=3)
REQ-028 Reset: reset=0 for 1 edge, with lpos preloaded to 3 mid-travel -> lpos=rpos=0, m=1, l=r=0, fault=0, stall=0.
REQ-029 Full open: m2l=m2r=1 for 8 cycles -> positions step 1,2,3,4 on edges 2,4,6,8; m=0 after edge 2; l=r=1 after edge 8; a further 4 cycles keep positions at 4.
REQ-030 Reversal: m2l=1 for 4 cycles (lpos=2), then l2m=1 for 4 cycles -> lpos 1 after edge 6, 0 after edge 8, m=1 after edge 8.
REQ-031 Bolt: bt=1, m2l=m2r=1 for 10 cycles -> positions stay 0 and m=1; then bt=0 -> lpos=1 after 2 further cycles.
REQ-032 Conflict: m2r=r2m=1 for 1 cycle with rpos=2 -> fault=1 next edge; rpos stays 2 despite 6 later r2m cycles; the left leaf still opens; reset clears fault.
REQ-033 Jam (DOOR_JAM_EN): m2l=1, jam=1 for 3 cycles -> lpos unchanged, stall=1 after edge 3 and held after jam=0; jam for 2 cycles only -> stall stays 0.

Source files
------------

// File: rtl/door_actuator_model_pkg.sv
// Shared types and default geometry for the door actuator model.
package door_actuator_model_pkg;

  typedef enum logic [2:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING,
    HALTED,
    FAULT
  } leaf_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_OPEN,
    DIR_CLOSE
  } dir_t;

  typedef logic [7:0] pos_t;

  localparam int DEF_TRAVEL    = 8;
  localparam int DEF_STEP_DIV  = 2;
  localparam int DEF_STALL_CYC = 6;

endpackage

// File: rtl/door_actuator_model_leaf.sv
// Single door leaf: state machine, step divider and saturating position.
module door_leaf
  import door_actuator_model_pkg::*;
#(
  parameter int TRAVEL   = DEF_TRAVEL,
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic open_cmd,
  input  logic close_cmd,
  input  logic bolt,
  input  logic freeze,
  output pos_t pos,
  output logic fault
);

  localparam pos_t       TRAVEL_P = pos_t'(TRAVEL);
  localparam logic [4:0] DIV_P    = 5'(STEP_DIV);

  leaf_state_t state;
  dir_t        dir, last_dir;
  logic [4:0]  div, cnt_next;
  pos_t        pos_up, pos_dn;
  logic        at_open, at_closed;

  // The bolt only masks opening; a suppressed open looks like no command.
  always_comb begin
    dir = DIR_NONE;
    if (open_cmd && !bolt)
      dir = DIR_OPEN;
    else if (close_cmd)
      dir = DIR_CLOSE;
    cnt_next  = (dir == last_dir) ? div + 5'd1 : 5'd1;
    pos_up    = pos + 8'd1;
    pos_dn    = pos - 8'd1;
    at_open   = (pos == TRAVEL_P);
    at_closed = (pos == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= CLOSED;
      pos      <= '0;
      div      <= '0;
      last_dir <= DIR_NONE;
    end else if (state != FAULT) begin
      if (open_cmd && close_cmd) begin
        state <= FAULT;
      end else if (!freeze) begin
        last_dir <= dir;
        case (dir)
          DIR_OPEN: begin
            if (at_open) begin
              state <= OPEN;
              div   <= '0;
            end else if (cnt_next == DIV_P) begin
              pos   <= pos_up;
              div   <= '0;
              state <= (pos_up == TRAVEL_P) ? OPEN : OPENING;
            end else begin
              div   <= cnt_next;
              state <= OPENING;
            end
          end
          DIR_CLOSE: begin
            if (at_closed) begin
              state <= CLOSED;
              div   <= '0;
            end else if (cnt_next == DIV_P) begin
              pos   <= pos_dn;
              div   <= '0;
              state <= (pos_dn == 8'd0) ? CLOSED : CLOSING;
            end else begin
              div   <= cnt_next;
              state <= CLOSING;
            end
          end
          default: begin
            div   <= '0;
            state <= at_closed ? CLOSED : (at_open ? OPEN : HALTED);
          end
        endcase
      end
    end
  end

  assign fault = (state == FAULT);

endmodule

// File: rtl/door_actuator_model.sv
// Two-leaf door actuator: limit decode, fault/stall flags, jam gating.
// Optional obstruction input and stall detection enabled by DOOR_JAM_EN.
module door_actuator_model
  import door_actuator_model_pkg::*;
#(
  parameter int TRAVEL    = DEF_TRAVEL,
  parameter int STEP_DIV  = DEF_STEP_DIV,
  parameter int STALL_CYC = DEF_STALL_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic m2l,
  input  logic l2m,
  input  logic m2r,
  input  logic r2m,
  input  logic bt,
`ifdef DOOR_JAM_EN
  input  logic jam,
`endif
  output logic l,
  output logic r,
  output logic m,
  output pos_t lpos,
  output pos_t rpos,
  output logic fault,
  output logic stall
);

  localparam pos_t TRAVEL_P = pos_t'(TRAVEL);

  if (TRAVEL < 2 || TRAVEL > 255 || STEP_DIV < 1 || STEP_DIV > 16 || STALL_CYC < 1) begin : g_param_check
    $error("door_actuator_model: parameter out of range");
  end

  logic freeze, lfault, rfault;

`ifdef DOOR_JAM_EN
  localparam logic [7:0] STALL_P = 8'(STALL_CYC);

  logic [7:0] stall_cnt, stall_inc;
  logic       motor_on;

  assign freeze    = jam;
  assign motor_on  = (m2l && !bt) || l2m || (m2r && !bt) || r2m;
  assign stall_inc = stall_cnt + 8'd1;

  // Counter saturates at the threshold; the flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else if (!jam) begin
      stall_cnt <= '0;
    end else if (motor_on) begin
      if (stall_inc >= STALL_P)
        stall <= 1'b1;
      if (stall_cnt < STALL_P)
        stall_cnt <= stall_inc;
    end
  end
`else
  assign freeze = 1'b0;
  assign stall  = 1'b0;
`endif

  door_leaf #(.TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV)) u_left (
    .clk       (clk),
    .reset     (reset),
    .open_cmd  (m2l),
    .close_cmd (l2m),
    .bolt      (bt),
    .freeze    (freeze),
    .pos       (lpos),
    .fault     (lfault)
  );

  door_leaf #(.TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV)) u_right (
    .clk       (clk),
    .reset     (reset),
    .open_cmd  (m2r),
    .close_cmd (r2m),
    .bolt      (bt),
    .freeze    (freeze),
    .pos       (rpos),
    .fault     (rfault)
  );

  assign l     = (lpos == TRAVEL_P);
  assign r     = (rpos == TRAVEL_P);
  assign m     = (lpos == 8'd0) && (rpos == 8'd0);
  assign fault = lfault || rfault;

endmodule
